// File: rtl/mig2stream_pkg.sv
// Shared stream data-type codes, MIG command encodings and FSM state type
// for the MIG read-side streamer.
package mig2stream_pkg;

  localparam int DTYPE_WIDTH = 4;

  localparam logic [DTYPE_WIDTH-1:0] DTYPE_NONE        = 4'h0;
  localparam logic [DTYPE_WIDTH-1:0] DTYPE_FRAME_START = 4'h1;
  localparam logic [DTYPE_WIDTH-1:0] DTYPE_PIXEL       = 4'h2;
  localparam logic [DTYPE_WIDTH-1:0] DTYPE_FRAME_END   = 4'h3;

  localparam logic [2:0] CMD_WRITE           = 3'd0;
  localparam logic [2:0] CMD_READ            = 3'd1;
  localparam logic [2:0] CMD_WRITE_PRECHARGE = 3'd2;
  localparam logic [2:0] CMD_READ_PRECHARGE  = 3'd3;
  localparam logic [2:0] CMD_REFRESH         = 3'd4;
  localparam logic [2:0] CMD_IDLE            = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_END
  } state_t;

endpackage

// File: rtl/mig2stream.sv
// Reads a committed frame from a MIG read port in 64-byte bursts and streams
// it out as 16-bit samples framed by FRAME_START / FRAME_END markers.
module mig2stream
  import mig2stream_pkg::*;
#(
  parameter int ADDR_WIDTH = 30,
  parameter int MAX_WORDS  = 32
) (
  input  logic                   rclk,
  input  logic                   rresetb,
  input  logic                   enable,
  input  logic                   frame_valid,
  input  logic [23:0]            frame_base,
  input  logic [29:0]            frame_len,
  output logic                   frame_ack,
  input  logic                   out_rdy,
  output logic                   dvo,
  output logic [DTYPE_WIDTH-1:0] dtypeo,
  output logic [15:0]            datao,
  output logic                   pR_cmd_en,
  output logic [2:0]             pR_cmd_instr,
  output logic [5:0]             pR_cmd_bl,
  output logic [ADDR_WIDTH-1:0]  pR_cmd_byte_addr,
  input  logic                   pR_cmd_full,
  output logic                   pR_rd_en,
  input  logic [31:0]            pR_rd_data,
  input  logic                   pR_rd_empty,
  output logic                   busy
);

  localparam logic [7:0] MAX_W = 8'(MAX_WORDS);

  state_t      state;
  logic [29:0] remaining;
  logic [28:0] pix_cnt;
  logic [6:0]  outstanding;
  logic        word_sel;
  logic        drain;
  logic        rd_en_q;
  logic        take;
  logic        room;

  assign take = (state == ST_DATA) && !pR_rd_empty && out_rdy;
  assign room = ({1'b0, outstanding} + 8'd16) <= MAX_W;
  assign busy = (state != ST_IDLE);

  // Drain pops every other cycle so the FWFT empty flag can catch up.
  assign pR_rd_en = (take && word_sel) || (drain && !pR_rd_empty && !rd_en_q);

  always_ff @(posedge rclk or negedge rresetb) begin
    if (!rresetb) rd_en_q <= 1'b0;
    else          rd_en_q <= pR_rd_en;
  end

  always_ff @(posedge rclk or negedge rresetb) begin
    if (!rresetb) begin
      outstanding <= '0;
    end else if (drain && pR_rd_empty) begin
      outstanding <= '0;
    end else begin
      unique case ({pR_cmd_en, pR_rd_en})
        2'b10:   outstanding <= outstanding + 7'd16;
        2'b11:   outstanding <= outstanding + 7'd15;
        2'b01:   if (outstanding != '0) outstanding <= outstanding - 7'd1;
        default: outstanding <= outstanding;
      endcase
    end
  end

  always_ff @(posedge rclk or negedge rresetb) begin
    if (!rresetb) begin
      state            <= ST_IDLE;
      dvo              <= 1'b0;
      dtypeo           <= '0;
      datao            <= '0;
      frame_ack        <= 1'b0;
      pR_cmd_en        <= 1'b0;
      pR_cmd_instr     <= CMD_IDLE;
      pR_cmd_bl        <= '0;
      pR_cmd_byte_addr <= '0;
      remaining        <= '0;
      pix_cnt          <= '0;
      word_sel         <= 1'b0;
      drain            <= 1'b0;
    end else begin
      pR_cmd_instr <= CMD_READ;
      pR_cmd_bl    <= 6'd15;
      dvo          <= 1'b0;
      frame_ack    <= 1'b0;
      pR_cmd_en    <= 1'b0;

      // The command address stays stable while cmd_en is high, then advances.
      if (pR_cmd_en) begin
        pR_cmd_byte_addr <= pR_cmd_byte_addr + ADDR_WIDTH'(64);
        remaining        <= remaining - 30'd64;
      end

      if (drain && pR_rd_empty) drain <= 1'b0;

      if (!enable) begin
        if (state != ST_IDLE) drain <= 1'b1;
        state    <= ST_IDLE;
        word_sel <= 1'b0;
      end else begin
        unique case (state)
          ST_IDLE: begin
            if (frame_valid && !drain) begin
              pR_cmd_byte_addr <= ADDR_WIDTH'({frame_base, 6'b0});
              remaining        <= frame_len;
              pix_cnt          <= frame_len[29:1];
              word_sel         <= 1'b0;
              state            <= ST_START;
            end
          end
          ST_START: begin
            if (out_rdy) begin
              dvo    <= 1'b1;
              dtypeo <= DTYPE_FRAME_START;
              datao  <= '0;
              state  <= ST_DATA;
            end
          end
          ST_DATA: begin
            if ((remaining != '0) && !pR_cmd_full && !pR_cmd_en && room)
              pR_cmd_en <= 1'b1;
            if (take) begin
              dvo      <= 1'b1;
              dtypeo   <= DTYPE_PIXEL;
              datao    <= word_sel ? pR_rd_data[31:16] : pR_rd_data[15:0];
              word_sel <= ~word_sel;
              pix_cnt  <= pix_cnt - 29'd1;
              if (pix_cnt == 29'd1) state <= ST_END;
            end
          end
          ST_END: begin
            if (out_rdy) begin
              dvo       <= 1'b1;
              dtypeo    <= DTYPE_FRAME_END;
              datao     <= '0;
              frame_ack <= 1'b1;
              word_sel  <= 1'b0;
              state     <= ST_IDLE;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mig2stream.sv
// Directed bench for mig2stream with a behavioural MIG read port (command
// latency, FWFT read FIFO) and a stream monitor.
module tb_mig2stream;
  import mig2stream_pkg::*;

  localparam int AW = 30;

  logic                   rclk = 1'b0;
  logic                   rresetb = 1'b1;
  logic                   enable = 1'b0;
  logic                   frame_valid = 1'b0;
  logic [23:0]            frame_base = '0;
  logic [29:0]            frame_len = '0;
  logic                   frame_ack;
  logic                   out_rdy = 1'b0;
  logic                   dvo;
  logic [DTYPE_WIDTH-1:0] dtypeo;
  logic [15:0]            datao;
  logic                   pR_cmd_en;
  logic [2:0]             pR_cmd_instr;
  logic [5:0]             pR_cmd_bl;
  logic [AW-1:0]          pR_cmd_byte_addr;
  logic                   pR_cmd_full = 1'b0;
  logic                   pR_rd_en;
  logic [31:0]            pR_rd_data = '0;
  logic                   pR_rd_empty = 1'b1;
  logic                   busy;

  mig2stream #(.ADDR_WIDTH(AW), .MAX_WORDS(32)) dut (
    .rclk(rclk), .rresetb(rresetb), .enable(enable),
    .frame_valid(frame_valid), .frame_base(frame_base), .frame_len(frame_len),
    .frame_ack(frame_ack), .out_rdy(out_rdy),
    .dvo(dvo), .dtypeo(dtypeo), .datao(datao),
    .pR_cmd_en(pR_cmd_en), .pR_cmd_instr(pR_cmd_instr), .pR_cmd_bl(pR_cmd_bl),
    .pR_cmd_byte_addr(pR_cmd_byte_addr), .pR_cmd_full(pR_cmd_full),
    .pR_rd_en(pR_rd_en), .pR_rd_data(pR_rd_data), .pR_rd_empty(pR_rd_empty),
    .busy(busy)
  );

  always #5 rclk = ~rclk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Stimulus knobs read by the MIG model.
  logic rdy_toggle = 1'b0;
  logic rdy_level  = 1'b1;
  logic full_mode  = 1'b0;
  int   mig_delay  = 2;

  // MIG model: decisions sampled mid-cycle, state updated just after the edge.
  logic [31:0] q[$];
  int          pend[$];
  int          cyc = 0;
  int          widx = 0;
  logic        rd_s, cmd_s, fv_s;

  always begin
    @(negedge rclk);
    rd_s  = pR_rd_en;
    cmd_s = pR_cmd_en;
    fv_s  = frame_valid && !busy;
    @(posedge rclk);
    #1;
    cyc++;
    if (!rresetb) begin
      q.delete();
      pend.delete();
    end else begin
      if (fv_s) widx = 0;
      if (rd_s && q.size() > 0) void'(q.pop_front());
      if (cmd_s) pend.push_back(cyc + mig_delay);
      while (pend.size() > 0 && pend[0] <= cyc) begin
        for (int k = 0; k < 16; k++) begin
          q.push_back({16'(2 * widx + 2), 16'(2 * widx + 1)});
          widx++;
        end
        void'(pend.pop_front());
      end
    end
    pR_rd_empty = (q.size() == 0);
    pR_rd_data  = (q.size() == 0) ? 32'h0 : q[0];
    out_rdy     = rdy_toggle ? ~out_rdy : rdy_level;
    pR_cmd_full = full_mode && ((cyc % 7) < 2);
  end

  // Stream / command monitor.
  logic [DTYPE_WIDTH+15:0] log_q[$];
  logic [AW-1:0]           cmd_q[$];
  int   ack_cnt = 0, rd_cnt = 0, out_tb = 0, out_max = 0, cmd_under_full = 0;
  logic full_prev = 1'b0;

  always @(negedge rclk) begin
    if (rresetb) begin
      if (frame_valid && !busy) begin
        out_tb  = 0;
        out_max = 0;
      end
      if (dvo) log_q.push_back({dtypeo, datao});
      if (frame_ack) ack_cnt++;
      if (pR_rd_en) begin
        rd_cnt++;
        out_tb--;
      end
      if (pR_cmd_en) begin
        cmd_q.push_back(pR_cmd_byte_addr);
        out_tb += 16;
        if (full_prev) cmd_under_full++;
        chk("cmd_fmt", 64'({pR_cmd_instr, pR_cmd_bl}), 64'({CMD_READ, 6'd15}));
      end
      if (out_tb > out_max) out_max = out_tb;
      full_prev = pR_cmd_full;
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge rclk);
      #1;
    end
  endtask

  task automatic start_frame(input logic [23:0] b, input logic [29:0] l);
    frame_base  = b;
    frame_len   = l;
    frame_valid = 1'b1;
    enable      = 1'b1;
    tick();
    frame_valid = 1'b0;
  endtask

  task automatic wait_ack(input int lim, input int ack0);
    for (int i = 0; i < lim && ack_cnt == ack0; i++) tick();
    tick(3);
  endtask

  function automatic logic [DTYPE_WIDTH+15:0] exp_ev(input int i, input int npix);
    if (i == 0) return {DTYPE_FRAME_START, 16'h0};
    if (i == npix + 1) return {DTYPE_FRAME_END, 16'h0};
    return {DTYPE_PIXEL, 16'(i)};
  endfunction

  function automatic int count_type(input int l0, input logic [DTYPE_WIDTH-1:0] t);
    int n = 0;
    for (int i = l0; i < log_q.size(); i++)
      if (log_q[i][DTYPE_WIDTH+15:16] == t) n++;
    return n;
  endfunction

  function automatic logic [AW-1:0] cmd_at(input int i);
    return (i < cmd_q.size()) ? cmd_q[i] : '1;
  endfunction

  task automatic check_seq(input string tag, input int l0, input int npix);
    int errs = 0;
    chk({tag, "_len"}, 64'(log_q.size() - l0), 64'(npix + 2));
    for (int i = 0; i < npix + 2; i++)
      if (l0 + i >= log_q.size() || log_q[l0 + i] !== exp_ev(i, npix)) errs++;
    chk({tag, "_data"}, 64'(errs), 64'(0));
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_dvo"},    64'(dvo), 0);
    chk({tag, "_dtype"},  64'(dtypeo), 0);
    chk({tag, "_data"},   64'(datao), 0);
    chk({tag, "_ack"},    64'(frame_ack), 0);
    chk({tag, "_busy"},   64'(busy), 0);
    chk({tag, "_cmden"},  64'(pR_cmd_en), 0);
    chk({tag, "_instr"},  64'(pR_cmd_instr), 64'(5));
    chk({tag, "_bl"},     64'(pR_cmd_bl), 0);
    chk({tag, "_addr"},   64'(pR_cmd_byte_addr), 0);
    chk({tag, "_rden"},   64'(pR_rd_en), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int l0, c0, a0, r0, u0, lr;

    #2 rresetb = 1'b0;
    tick(3);
    check_reset_outputs("rst");
    rresetb = 1'b1;
    tick(2);
    chk("idle_busy", 64'(busy), 0);
    chk("idle_no_ev", 64'(log_q.size()), 0);

    // Basic frame: two bursts, 64 pixels.
    l0 = log_q.size(); c0 = cmd_q.size(); a0 = ack_cnt; r0 = rd_cnt;
    start_frame(24'h10, 30'd128);
    wait_ack(400, a0);
    check_seq("t1", l0, 64);
    chk("t1_ncmd",  64'(cmd_q.size() - c0), 64'(2));
    chk("t1_addr0", 64'(cmd_at(c0)), 64'h400);
    chk("t1_addr1", 64'(cmd_at(c0 + 1)), 64'h440);
    chk("t1_ack",   64'(ack_cnt - a0), 64'(1));
    chk("t1_rden",  64'(rd_cnt - r0), 64'(32));
    chk("t1_busy",  64'(busy), 0);

    // Downstream stalls every other cycle.
    rdy_toggle = 1'b1;
    l0 = log_q.size(); a0 = ack_cnt; r0 = rd_cnt;
    start_frame(24'h10, 30'd128);
    wait_ack(800, a0);
    check_seq("t2", l0, 64);
    chk("t2_rden", 64'(rd_cnt - r0), 64'(32));
    chk("t2_ack",  64'(ack_cnt - a0), 64'(1));
    rdy_toggle = 1'b0;
    tick(2);

    // Long frame, slow MIG, intermittent command-FIFO full.
    mig_delay = 20; full_mode = 1'b1;
    l0 = log_q.size(); c0 = cmd_q.size(); a0 = ack_cnt; u0 = cmd_under_full;
    start_frame(24'h0, 30'd2048);
    wait_ack(6000, a0);
    check_seq("t3", l0, 1024);
    chk("t3_ncmd",      64'(cmd_q.size() - c0), 64'(32));
    chk("t3_outmax",    64'(out_max), 64'(32));
    chk("t3_out_final", 64'(out_tb), 64'(0));
    chk("t3_cmd_full",  64'(cmd_under_full - u0), 64'(0));
    chk("t3_last_addr", 64'(cmd_at(c0 + 31)), 64'(31 * 64));
    mig_delay = 2; full_mode = 1'b0;
    tick(2);

    // Abort mid-frame, drain, then a clean frame.
    l0 = log_q.size(); a0 = ack_cnt;
    start_frame(24'h20, 30'd128);
    for (int i = 0; i < 300 && count_type(l0, DTYPE_PIXEL) < 10; i++) tick();
    enable = 1'b0;
    tick();
    chk("t4_busy_next", 64'(busy), 0);
    for (int i = 0; i < 300 && !(q.size() == 0 && pend.size() == 0 && !pR_rd_en); i++) tick();
    tick(4);
    chk("t4_fifo_empty", 64'(pR_rd_empty), 64'(1));
    chk("t4_q_size",     64'(q.size()), 0);
    chk("t4_no_end",     64'(count_type(l0, DTYPE_FRAME_END)), 0);
    chk("t4_no_ack",     64'(ack_cnt - a0), 0);
    chk("t4_busy",       64'(busy), 0);
    chk("t4_rden_idle",  64'(pR_rd_en), 0);
    l0 = log_q.size(); c0 = cmd_q.size(); a0 = ack_cnt;
    start_frame(24'h20, 30'd128);
    wait_ack(400, a0);
    check_seq("t4r", l0, 64);
    chk("t4r_addr0", 64'(cmd_at(c0)), 64'h800);
    chk("t4r_addr1", 64'(cmd_at(c0 + 1)), 64'h840);
    chk("t4r_ack",   64'(ack_cnt - a0), 64'(1));

    // Address wrap at the top of the space.
    l0 = log_q.size(); c0 = cmd_q.size(); a0 = ack_cnt;
    start_frame(24'hFFFFFF, 30'd128);
    wait_ack(400, a0);
    check_seq("t5", l0, 64);
    chk("t5_addr0", 64'(cmd_at(c0)), 64'h3FFF_FFC0);
    chk("t5_addr1", 64'(cmd_at(c0 + 1)), 64'h0);

    // Reset in the middle of DATA.
    l0 = log_q.size();
    start_frame(24'h30, 30'd128);
    for (int i = 0; i < 300 && count_type(l0, DTYPE_PIXEL) < 5; i++) tick();
    rresetb = 1'b0;
    #1;
    check_reset_outputs("t6rst");
    lr = log_q.size(); c0 = cmd_q.size();
    tick(3);
    rresetb = 1'b1;
    tick(6);
    chk("t6_no_ev",  64'(log_q.size() - lr), 0);
    chk("t6_no_cmd", 64'(cmd_q.size() - c0), 0);
    chk("t6_busy",   64'(busy), 0);
    l0 = log_q.size(); c0 = cmd_q.size(); a0 = ack_cnt;
    start_frame(24'h30, 30'd128);
    wait_ack(400, a0);
    check_seq("t6r", l0, 64);
    chk("t6r_addr0", 64'(cmd_at(c0)), 64'hC00);
    chk("t6r_ack",   64'(ack_cnt - a0), 64'(1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mig2stream.md
MIG2STREAM -- requirements
Module: mig2stream

Interface
REQ-001 Parameter ADDR_WIDTH, default 30, MIG byte-address width.
REQ-002 Parameter MAX_WORDS, default 32, max 32-bit words outstanding in MIG read FIFO.
REQ-003 rclk  in  1  clock; all logic on rising edge.
REQ-004 rresetb  in  1  reset, asynchronous, active-low.
REQ-005 enable  in  1  block enable; low = abort and flush.
REQ-006 frame_valid  in  1  committed frame available.
REQ-007 frame_base  in  24  frame block index; byte address = frame_base*64.
REQ-008 frame_len  in  30  frame length in bytes, multiple of 64, nonzero.
REQ-009 frame_ack  out  1  one-cycle pulse: frame fully streamed, base consumed.
REQ-010 out_rdy  in  1  downstream may accept a sample this cycle.
REQ-011 dvo / dtypeo / datao  out  1 / DTYPE_WIDTH / 16  output stream.
REQ-012 pR_cmd_en, pR_cmd_instr[2:0], pR_cmd_bl[5:0], pR_cmd_byte_addr[ADDR_WIDTH-1:0]  out  MIG read command.
REQ-013 pR_cmd_full  in  1; pR_rd_en  out  1; pR_rd_data  in  32; pR_rd_empty  in  1 (first-word-fall-through).
REQ-014 busy  out  1  high in any state other than IDLE.

Function
REQ-015 FSM states IDLE, START, DATA, END; leaves IDLE only when enable && frame_valid.
REQ-016 IDLE->START: latch frame_base*64 into cmd address, frame_len into remaining-bytes, frame_len/2 into pixel count.
REQ-017 START: if out_rdy, emit dvo=1, dtypeo=DTYPE_FRAME_START, datao=0 next cycle; ->DATA.
REQ-018 DATA command issue: pR_cmd_en=1 for one cycle when remaining-bytes>0, !pR_cmd_full, !pR_cmd_en, outstanding+16<=MAX_WORDS.
REQ-019 pR_cmd_instr always CMD_READ (1); pR_cmd_bl=15; address advances by 64 and remaining-bytes drops by 64 the cycle after pR_cmd_en.
REQ-020 Outstanding counter, 7 bits: +16 on cmd_en, -1 on rd_en, +15 on both; never negative, never exceeds MAX_WORDS.
REQ-021 Unpack: low half [15:0] emitted first, then [31:16]; word_sel toggles per emitted sample.
REQ-022 Sample emitted when DATA && !pR_rd_empty && out_rdy; registered output, one-cycle latency: dvo=1, dtypeo=DTYPE_PIXEL, datao=selected half.
REQ-023 pR_rd_en combinational = DATA && !pR_rd_empty && out_rdy && word_sel (pops word on high half).
REQ-024 dvo=0 whenever out_rdy=0 or pR_rd_empty=1 in DATA; no sample duplicated or dropped across stalls.
REQ-025 Pixel count decrements per emitted sample; at final sample ->END.
REQ-026 END: if out_rdy, emit dtypeo=DTYPE_FRAME_END, pulse frame_ack, clear word_sel; ->IDLE.
REQ-027 frame_valid ignored outside IDLE; back-to-back frames incur exactly one IDLE cycle.
REQ-028 enable low mid-frame: ->IDLE next cycle, pR_cmd_en=0, no FRAME_END, no frame_ack; pR_rd_en = !pR_rd_empty && !prev pR_rd_en (drain) until empty and outstanding cleared to 0.
REQ-029 Address arithmetic wraps modulo 2^ADDR_WIDTH.

Reset
REQ-030 On rresetb low: state IDLE, dvo=0, dtypeo=0, datao=0, frame_ack=0, busy=0, pR_cmd_en=0, pR_cmd_instr=CMD_IDLE (5), pR_cmd_bl=0, pR_cmd_byte_addr=0, pR_rd_en=0, counters and word_sel=0.
REQ-031 Reset mid-frame discards all progress; no output event follows until next frame_valid after release.

Structure
REQ-032 DTYPE_* codes and DTYPE_WIDTH come from shared dtypes.v.
REQ-033 MIG command codes (CMD_WRITE..CMD_IDLE) live in a shared MIG constants include shared with the write-side block.
REQ-034 Single module; no sub-module; MIG read FIFO is external.

Verification
REQ-035 frame_base=0x10, frame_len=128, out_rdy=1, MIG model returns words 0x00020001.. -> two commands at 0x400, 0x440 bl=15; FRAME_START, 64 pixels 1,2,3..64, FRAME_END, one frame_ack.
REQ-036 Same frame, out_rdy toggled 1/0 every cycle -> identical 64-sample sequence, pR_rd_en count 32.
REQ-037 frame_len=2048, MIG model delays data 20 cycles -> outstanding never >32, no command while pR_cmd_full=1.
REQ-038 enable dropped after 10 pixels with 12 words in MIG FIFO -> no FRAME_END/frame_ack, FIFO drained to empty, busy=0, new frame then streams correctly.
REQ-039 frame_base=0xFFFFFF, frame_len=128 -> second command address wraps to 0x00000000.
REQ-040 rresetb asserted mid-DATA -> all outputs at reset values same cycle, stream restarts cleanly on next frame_valid.
